// File: rtl/timer_cmp_scheduler.sv
// Round-robin mtimecmp scanner: one shared 64-bit comparator visits one core per cycle
// against a per-sweep snapshot of mtime and raises sticky per-core timer interrupts.
module timer_cmp_scheduler #(
    parameter int NR_CORES = 4
) (
    input  logic                                            HCLK,
    input  logic                                            HRESETn,
    input  logic                                            enable_i,
    input  logic [63:0]                                     time_i,
    input  logic [64*NR_CORES-1:0]                          mtimecmp_i,
    input  logic [NR_CORES-1:0]                             cmp_wr_i,
    output logic [NR_CORES-1:0]                             timer_irq_o,
    output logic [((NR_CORES > 1) ? $clog2(NR_CORES) : 1)-1:0] cur_core_o,
    output logic                                            busy_o,
    output logic                                            sweep_done_o
);

    localparam int CW = (NR_CORES > 1) ? $clog2(NR_CORES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NR_CORES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [63:0]         snap_q, snap_d;
    logic [NR_CORES-1:0] irq_q, irq_d;
    logic                busy_q, busy_d;
    logic                sweep_done_q, sweep_done_d;

    logic [63:0]         cmp_sel;
    logic                hit;
    logic [NR_CORES-1:0] set_vec;

    // Shared comparator: select the mtimecmp of the core owning this slot.
    always_comb begin
        cmp_sel = '0;
        for (int k = 0; k < NR_CORES; k++) begin
            if (idx_q == CW'(k)) begin
                cmp_sel = mtimecmp_i[64*k +: 64];
            end
        end
    end

    assign hit = (state_q == SCAN) && (snap_q >= cmp_sel);

    always_comb begin
        set_vec = '0;
        for (int k = 0; k < NR_CORES; k++) begin
            set_vec[k] = hit && (idx_q == CW'(k));
        end
    end

    // A write clears unconditionally, so a compare made against the stale value is dropped.
    assign irq_d = (irq_q | set_vec) & ~cmp_wr_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    snap_d  = time_i;
                end
            end
            SCAN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (idx_q == LAST) begin
                    idx_d  = '0;
                    snap_d = time_i;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are computed from next-state so they come straight out of flops.
    always_comb begin
        busy_d       = (state_d == SCAN);
        sweep_done_d = (state_d == SCAN) && (idx_d == LAST);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            snap_q       <= '0;
            irq_q        <= '0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            irq_q        <= irq_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign timer_irq_o  = irq_q;
    assign cur_core_o   = idx_q;
    assign busy_o       = busy_q;
    assign sweep_done_o = sweep_done_q;

endmodule

// File: tb/tb_timer_cmp_scheduler.sv
// Bench for timer_cmp_scheduler: directed scenarios plus randomized traffic against a
// cycle-level reference model; a second instance covers the single-core configuration.
module tb_timer_cmp_scheduler;

    localparam int N  = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              en;
    logic [63:0]       tim;
    logic [64*N-1:0]   cmp;
    logic [N-1:0]      wr;
    logic [N-1:0]      irq;
    logic [CW-1:0]     cur;
    logic              busy;
    logic              sdone;

    timer_cmp_scheduler #(.NR_CORES(N)) dut (
        .HCLK(clk), .HRESETn(rst_n), .enable_i(en), .time_i(tim),
        .mtimecmp_i(cmp), .cmp_wr_i(wr), .timer_irq_o(irq),
        .cur_core_o(cur), .busy_o(busy), .sweep_done_o(sdone)
    );

    logic        rst1_n;
    logic        en1;
    logic [63:0] tim1;
    logic [63:0] cmp1;
    logic        wr1;
    logic        irq1;
    logic        cur1;
    logic        busy1;
    logic        sdone1;

    timer_cmp_scheduler #(.NR_CORES(1)) dut1 (
        .HCLK(clk), .HRESETn(rst1_n), .enable_i(en1), .time_i(tim1),
        .mtimecmp_i(cmp1), .cmp_wr_i(wr1), .timer_irq_o(irq1),
        .cur_core_o(cur1), .busy_o(busy1), .sweep_done_o(sdone1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: scanning flag, current slot, sweep snapshot, interrupt bits.
    bit          m_scan;
    int          m_slot;
    logic [63:0] m_snap;
    logic [N-1:0] m_irq;
    logic [7:0]  exp_q[$];

    task automatic model_reset();
        m_scan = 0;
        m_slot = 0;
        m_snap = '0;
        m_irq  = '0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_scan && (m_snap >= cmp[64*m_slot +: 64])) m_irq[m_slot] = 1'b1;
            m_irq = m_irq & ~wr;
            if (!m_scan) begin
                if (en) begin
                    m_scan = 1;
                    m_slot = 0;
                    m_snap = tim;
                end
            end else if (!en) begin
                m_scan = 0;
            end else begin
                if (m_slot == N - 1) m_snap = tim;
                m_slot = (m_slot + 1) % N;
            end
        end
        exp_q.push_back({m_scan, (m_scan && m_slot == N - 1), m_slot[CW-1:0], m_irq});
    endtask

    task automatic check_outputs();
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("irq", 64'(irq), 64'(e[3:0]));
            chk("cur", 64'(cur), 64'(e[5:4]));
            chk("sweep_done", 64'(sdone), 64'(e[6]));
            chk("busy", 64'(busy), 64'(e[7]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_irq"}, 64'(irq), 64'd0);
        chk({tag, "_cur"}, 64'(cur), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sdone"}, 64'(sdone), 64'd0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 2 * N && m_slot != s; i++) step();
        chk("wait_slot", 64'(m_slot), 64'(s));
    endtask

    int first_set[N];
    logic [N-1:0] saved_irq;

    initial begin
        rst_n = 1'b0; en = 1'b0; tim = '0; cmp = '0; wr = '0;
        rst1_n = 1'b0; en1 = 1'b0; tim1 = '0; cmp1 = '0; wr1 = 1'b0;
        model_reset();
        #2;
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_cur", 64'(cur), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst1_irq", 64'(irq1), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 64'(busy), 64'd0);

        // Ramp: core k expires at 100*(k+1).
        for (int k = 0; k < N; k++) begin
            cmp[64*k +: 64] = 64'(100 * (k + 1));
            first_set[k] = -1;
        end
        en = 1'b1;
        for (int c = 0; c < 420; c++) begin
            tim = 64'(c);
            step();
            for (int k = 0; k < N; k++) begin
                if (irq[k] && first_set[k] < 0) first_set[k] = c;
            end
        end
        chk("lat0_seen", 64'(first_set[0] >= 100), 64'd1);
        chk("lat0_bound", 64'(first_set[0] - 100 <= 9), 64'd1);
        for (int k = 1; k < N; k++) begin
            chk("irq_order", 64'(first_set[k] > first_set[k-1]), 64'd1);
            chk("lat_bound", 64'(first_set[k] - 100 * (k + 1) <= 2 * N + 1), 64'd1);
        end

        // Clear at the very slot whose compare is true: clear wins, re-sets one sweep later.
        wait_slot(1);
        wr[1] = 1'b1;
        step();
        wr = '0;
        chk("clr_coincide", 64'(irq[1]), 64'd0);
        step(); step(); step();
        chk("clr_hold", 64'(irq[1]), 64'd0);
        step();
        chk("reassert", 64'(irq[1]), 64'd1);

        // Reprogram core 2 to the maximum value: stays clear.
        cmp[128 +: 64] = '1;
        wr[2] = 1'b1;
        tim = tim + 1;
        step();
        wr = '0;
        chk("max_clr", 64'(irq[2]), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tim = tim + 1;
            step();
        end
        chk("max_stay", 64'(irq[2]), 64'd0);

        // Drop enable mid-sweep at slot 2.
        wait_slot(2);
        en = 1'b0;
        step();
        chk("drop_cur", 64'(cur), 64'd2);
        chk("drop_busy", 64'(busy), 64'd0);
        saved_irq = irq;
        for (int i = 0; i < 3; i++) begin
            tim = tim + 5;
            step();
        end
        chk("idle_frozen", 64'(irq), 64'(saved_irq));
        chk("idle_cur", 64'(cur), 64'd2);
        en = 1'b1;
        step();
        chk("reen_cur", 64'(cur), 64'd0);
        chk("reen_busy", 64'(busy), 64'd1);

        // Reset at slot 3 with irq = 1011.
        wait_slot(3);
        chk("pre_rst_irq", 64'(irq), 64'b1011);
        #2;
        async_reset("midrst");
        step();
        chk("post_rst_cur", 64'(cur), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd1);

        // Single-core instance.
        rst1_n = 1'b1; en1 = 1'b1; tim1 = 64'd5; cmp1 = 64'd5;
        step();
        chk("n1_busy", 64'(busy1), 64'd1);
        chk("n1_sdone_a", 64'(sdone1), 64'd1);
        chk("n1_cur", 64'(cur1), 64'd0);
        step();
        chk("n1_irq", 64'(irq1), 64'd1);
        chk("n1_sdone_b", 64'(sdone1), 64'd1);

        // Randomized traffic.
        tim = 64'd1000;
        for (int c = 0; c < 3000; c++) begin
            wr = '0;
            tim = tim + 64'($urandom_range(0, 3));
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 15) == 0) begin
                    wr[k] = 1'b1;
                    if ($urandom_range(0, 7) == 0) cmp[64*k +: 64] = '1;
                    else cmp[64*k +: 64] = tim + 64'($urandom_range(0, 60)) - 64'd30;
                end
            end
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
